// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between the
// instruction-fetch port and the load/store port. Load/store has priority, and
// fetch is forced through after MAX_WAIT consecutive denials. Each access goes
// through IDLE -> ISSUE -> WAIT -> RESP, so the latency is uniform for loads,
// stores and fetches.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wstrb,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  ls_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [LCW-1:0] LAT_INIT = LCW'(MEM_LAT - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    logic [LCW-1:0] lat_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           store_op;
    logic           fetch_forced;
    logic           ls_win;

    // Arbitration: load/store wins unless fetch has been denied MAX_WAIT times
    always_comb begin
        fetch_forced = 1'b0;
        ls_win       = 1'b0;
        fetch_forced = if_req && (wait_cnt == WAIT_MAX);
        ls_win       = ls_req && !fetch_forced;
    end

    // Transaction FSM with registered memory controls, responses and status
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            wait_cnt  <= '0;
            store_op  <= 1'b0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            ls_rdata  <= '0;
            ls_valid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_win) begin
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        mem_wstrb <= ls_wstrb;
                        mem_we    <= ls_we;
                        mem_en    <= 1'b1;
                        store_op  <= ls_we;
                        owner     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                        if (if_req && (wait_cnt != WAIT_MAX))
                            wait_cnt <= wait_cnt + 1'b1;
                    end else if (if_req) begin
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        mem_we    <= 1'b0;
                        mem_en    <= 1'b1;
                        store_op  <= 1'b0;
                        owner     <= 1'b0;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner) begin
                            ls_rdata <= store_op ? '0 : mem_rdata;
                            ls_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes the expected
// memory accesses and completions; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        owner;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    // Memory contents: address 0x10 holds an instruction, everything else is addr ^ 0xC0DE0000
    assign mem_rdata = (mem_addr == 32'h10) ? 32'h00500093 : (mem_addr ^ 32'hC0DE0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        own;
        int unsigned cyc;
    } acc_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int unsigned cyc;
    } resp_t;

    acc_t  acc_q[$];
    resp_t resp_q[$];
    acc_t  a;
    resp_t r;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic own, input int unsigned c);
        acc_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.own = own; t.cyc = c;
        acc_q.push_back(t);
    endtask

    task automatic push_resp(input logic port, input logic [31:0] data, input int unsigned c);
        resp_t t;
        t.port = port; t.data = data; t.cyc = c;
        resp_q.push_back(t);
    endtask

    // Waits (bounded) for the given port's valid, then advances to the next cycle's drive point
    task automatic wait_valid(input logic port, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((port ? ls_valid : if_valid) === 1'b1) seen = 1'b1;
        end
        check(name, {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every memory access and every completion is popped and compared
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_en === 1'b1) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_mem_en", 32'd1, 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("acc_cycle", cyc, a.cyc);
                    check("acc_addr", mem_addr, a.addr);
                    check("acc_we", {31'b0, mem_we}, {31'b0, a.we});
                    check("acc_owner", {31'b0, owner}, {31'b0, a.own});
                    check("acc_busy", {31'b0, busy}, 32'd1);
                    if (a.we) begin
                        check("acc_wdata", mem_wdata, a.wdata);
                        check("acc_wstrb", {28'b0, mem_wstrb}, {28'b0, a.wstrb});
                    end
                end
            end
            if (if_valid === 1'b1 || ls_valid === 1'b1) begin
                check("both_valid", {31'b0, if_valid & ls_valid}, 32'd0);
                if (resp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_port", {31'b0, ls_valid}, {31'b0, r.port});
                    check("resp_data", r.port ? ls_rdata : if_rdata, r.data);
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_busy", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int unsigned n;

    initial begin
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wdata = '0; ls_wstrb = '0;

        // Reset held with both requests high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_ls_valid", {31'b0, ls_valid}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_owner", {31'b0, owner}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);

        // Release: load/store wins first, fetch follows in the next IDLE
        @(posedge clk); #1;
        reset = 1'b1;
        n = cyc;
        push_acc(1'b0, 32'h200, 32'h0, 4'h0, 1'b1, n + 1);
        push_resp(1'b1, 32'hC0DE0200, n + 4);
        push_acc(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, n + 6);
        push_resp(1'b0, 32'hC0DE0020, n + 9);
        wait_valid(1'b1, "to_rst_ls");
        ls_req = 1'b0;
        wait_valid(1'b0, "to_rst_if");
        if_req = 1'b0;

        // Single fetch
        n = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        push_acc(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, n + 1);
        push_resp(1'b0, 32'h00500093, n + 4);
        wait_valid(1'b0, "to_fetch");
        if_req = 1'b0;

        // Store returns zero read data
        n = cyc;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'hF;
        push_acc(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, n + 1);
        push_resp(1'b1, 32'h0, n + 4);
        wait_valid(1'b1, "to_store");
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0; ls_wstrb = '0;

        // Contention: load/store first, fetch 5 cycles later
        n = cyc;
        ls_req = 1'b1; ls_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h24;
        push_acc(1'b0, 32'h300, 32'h0, 4'h0, 1'b1, n + 1);
        push_resp(1'b1, 32'hC0DE0300, n + 4);
        push_acc(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, n + 6);
        push_resp(1'b0, 32'hC0DE0024, n + 9);
        wait_valid(1'b1, "to_cont_ls");
        ls_req = 1'b0;
        wait_valid(1'b0, "to_cont_if");
        if_req = 1'b0;

        // Starvation: four load/store grants, then fetch is forced, then load/store resumes
        n = cyc;
        ls_req = 1'b1; ls_addr = 32'h400;
        if_req = 1'b1; if_addr = 32'h30;
        push_acc(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, n + 1);
        push_resp(1'b1, 32'hC0DE0400, n + 4);
        push_acc(1'b0, 32'h404, 32'h0, 4'h0, 1'b1, n + 6);
        push_resp(1'b1, 32'hC0DE0404, n + 9);
        push_acc(1'b0, 32'h408, 32'h0, 4'h0, 1'b1, n + 11);
        push_resp(1'b1, 32'hC0DE0408, n + 14);
        push_acc(1'b0, 32'h40C, 32'h0, 4'h0, 1'b1, n + 16);
        push_resp(1'b1, 32'hC0DE040C, n + 19);
        push_acc(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, n + 21);
        push_resp(1'b0, 32'hC0DE0030, n + 24);
        push_acc(1'b0, 32'h410, 32'h0, 4'h0, 1'b1, n + 26);
        push_resp(1'b1, 32'hC0DE0410, n + 29);
        for (int k = 0; k < 4; k++) begin
            wait_valid(1'b1, "to_starve_ls");
            ls_addr = 32'h400 + 32'(4 * (k + 1));
        end
        wait_valid(1'b0, "to_starve_if");
        if_req = 1'b0;
        wait_valid(1'b1, "to_starve_resume");
        ls_req = 1'b0;

        // Reset during WAIT of a load: abandoned, then the held request completes
        n = cyc;
        ls_req = 1'b1; ls_addr = 32'h500;
        push_acc(1'b0, 32'h500, 32'h0, 4'h0, 1'b1, n + 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n = cyc;
        push_acc(1'b0, 32'h500, 32'h0, 4'h0, 1'b1, n + 1);
        push_resp(1'b1, 32'hC0DE0500, n + 4);
        wait_valid(1'b1, "to_rst_wait");
        ls_req = 1'b0;

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("acc_q_drained", acc_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified instruction/data memory between the processor's instruction-fetch port and its load/store port. Each request is held until done. The block picks a winner, issues one memory access, waits the fixed memory latency, then returns read data with a one-cycle valid pulse. It sits between the processor core and memory, and its `busy` output freezes the core while an access is in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `MEM_LAT`, 2, memory read latency in cycles (≥1)
- `MAX_WAIT`, 4, consecutive denied fetch arbitrations before fetch is forced to win (≥1)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `if_req`  in  1  fetch request, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch data, valid while `if_valid`
- `if_valid`  out  1  one-cycle completion pulse for fetch
- `ls_req`  in  1  load/store request, held until `ls_valid`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_wstrb`  in  DATA_W/8  store byte enables
- `ls_rdata`  out  DATA_W  load data, valid while `ls_valid`
- `ls_valid`  out  1  one-cycle completion pulse for load/store
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered access controls
- `mem_rdata`  in  DATA_W  memory read data
- `owner`  out  1  current grant owner: 0 = fetch, 1 = load/store
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** samples `if_req` and `ls_req`.
  - No request: stay in IDLE.
  - Otherwise: select the winner, latch its address, data, strobe and we into the `mem_*` registers, set `owner`, go to ISSUE.
- **Arbitration:** load/store has priority. When both requests are high, fetch loses and `wait_cnt` increments.
  - If `wait_cnt == MAX_WAIT` at arbitration, fetch wins instead.
  - `wait_cnt` clears whenever fetch is granted.
  - `wait_cnt` saturates at MAX_WAIT.
- **ISSUE:** `mem_en=1` for exactly this cycle. `mem_we` equals the latched `ls_we`, and is 0 for fetch. Load counter with MEM_LAT−1, go to WAIT.
- **WAIT:** counter decrements each cycle. When the counter is 0 (cycle ISSUE+MEM_LAT), capture `mem_rdata` into the owner's rdata register and go to RESP.
  - Stores also traverse WAIT, so latency is uniform. For a store, `ls_rdata` is loaded with 0.
- **RESP:** the owner's valid is 1 for this cycle only. Requests are ignored in RESP. Go to IDLE.
  - A requester still asserting req in the cycle after RESP has made a new request.
- `if_rdata`/`ls_rdata` hold their last value until the next completion to that port.
- `mem_addr`, `mem_wdata`, `mem_wstrb` hold their values outside ISSUE. `mem_en` and `mem_we` are 0 outside ISSUE.
- The non-owner's valid never asserts during a transaction.

## Timing
- Reset (`reset=0` at a rising edge):
  - FSM goes to IDLE.
  - `wait_cnt`, latency counter, all valid/`mem_en`/`mem_we`/`owner`/`busy` outputs are 0.
  - All data/address output registers are 0.
  - Reset dominates requests in the same cycle.
- Reset mid-transaction (ISSUE/WAIT/RESP): the in-flight access is abandoned, its `mem_rdata` is ignored, and no valid pulse is emitted.
- Request sampled in IDLE cycle c:
  - `mem_en` in cycle c+1.
  - Data captured at the end of cycle c+1+MEM_LAT.
  - Valid in cycle c+2+MEM_LAT; c+4 for MEM_LAT=2.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- `busy` is high from c+1 through the RESP cycle inclusive.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles with both requests high → all outputs 0, no `mem_en`. Release → first grant goes to load/store.
- **Single fetch:** `if_req` at `if_addr=0x00000010`, memory returns 0x00500093 → `mem_en=1`, `mem_addr=0x10`, `mem_we=0` at c+1; `if_valid=1`, `if_rdata=0x00500093` at c+4; `ls_valid` stays 0.
- **Store:** `ls_we=1`, `ls_addr=0x100`, `ls_wdata=0xDEADBEEF`, `ls_wstrb=0xF` → at c+1 `mem_we=1`, `mem_wdata=0xDEADBEEF`, `mem_wstrb=0xF`; `ls_valid` at c+4 with `ls_rdata=0`.
- **Contention:** both requests rise in the same cycle → load/store completes first at c+4. Fetch is granted in the following IDLE, and `if_valid` arrives 5 cycles after `ls_valid`.
- **Starvation:** `ls_req` held continuously, `if_req` high → 4 load/store completions, then the 5th grant goes to fetch (`owner=0`), `wait_cnt` returns to 0, and load/store resumes after.
- **Reset mid-WAIT:** assert `reset=0` during WAIT of a load → no `ls_valid` pulse. After release, the same request completes in 4 cycles with correct data.
